// File: rtl/thresh_fifo.sv
// thresh_fifo: synchronous FIFO with programmable almost-full / almost-empty flags.
//
// Ports:
//   clk          - clock, all state changes on rising edge
//   reset_L      - asynchronous active-low reset
//   wr_en        - write request; data_in is stored when the write is accepted
//   data_in      - write data
//   rd_en        - read request; popped word appears on data_out next cycle
//   af_thr       - almost-full threshold (0 disables almost_full)
//   ae_thr       - almost-empty threshold
//   data_out     - registered read data, holds its value when no read is accepted
//   valid_out    - data_out carries a word popped on the previous edge
//   empty, full  - occupancy flags derived from count
//   almost_full  - count >= af_thr (when af_thr != 0)
//   almost_empty - count <= ae_thr
//   error        - sticky overflow/underflow indication, cleared only by reset
//   count        - current occupancy, 0..DEPTH
module thresh_fifo #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned THR_W  = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic [THR_W-1:0]  af_thr,
    input  logic [THR_W-1:0]  ae_thr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              error_q, error_d;

    logic              wr_acc;
    logic              rd_acc;
    logic              overflow;
    logic              underflow;
    logic [ADDR_W:0]   af_ext;
    logic [ADDR_W:0]   ae_ext;

    // Flags come straight from the count register.
    assign empty = (count_q == '0);
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));

    // A write into a full FIFO still lands when a read frees the slot the same cycle.
    assign wr_acc    = wr_en && (!full || rd_en);
    assign rd_acc    = rd_en && !empty;
    assign overflow  = wr_en && full && !rd_en;
    assign underflow = rd_en && empty;

    // Thresholds are zero-extended to the count width and used live, not latched.
    assign af_ext       = (ADDR_W+1)'(af_thr);
    assign ae_ext       = (ADDR_W+1)'(ae_thr);
    assign almost_full  = (af_ext != '0) && (count_q >= af_ext);
    assign almost_empty = (count_q <= ae_ext);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        error_d     = error_q | overflow | underflow;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
            data_out_d  = mem[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    // Storage needs no reset; a read of a just-written full slot sees the old word.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign error     = error_q;
    assign count     = count_q;

endmodule

// File: tb/tb_thresh_fifo.sv
module tb_thresh_fifo;

    logic       clk;
    logic       reset_L;
    logic       wr_en;
    logic [5:0] data_in;
    logic       rd_en;
    logic [1:0] af_thr;
    logic [1:0] ae_thr;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    thresh_fifo #(
        .DATA_W(6),
        .ADDR_W(2),
        .THR_W (2)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .af_thr      (af_thr),
        .ae_thr      (ae_thr),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .error       (error),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request; outputs sampled 1ns after the edge.
    task automatic cyc(input logic we, input logic [5:0] din, input logic re);
        wr_en   = we;
        data_in = din;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #3;
        reset_L = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        af_thr  = 2'd3;
        ae_thr  = 2'd1;

        // Reset state
        #2;
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_error", error, 0);
        check("rst_count", count, 0);
        check("rst_valid", valid_out, 0);
        check("rst_dout", data_out, 0);
        #5;
        reset_L = 1'b1;
        cyc(0, 6'h00, 0);
        check("idle_count", count, 0);
        check("idle_empty", empty, 1);

        // Write and read-back
        cyc(1, 6'h05, 0);
        check("wr1_count", count, 1);
        check("wr1_aempty", almost_empty, 1);
        cyc(1, 6'h0A, 0);
        check("wr2_afull", almost_full, 0);
        cyc(1, 6'h15, 0);
        check("wr3_count", count, 3);
        check("wr3_afull", almost_full, 1);
        check("wr3_aempty", almost_empty, 0);
        check("wr3_valid", valid_out, 0);
        cyc(0, 6'h00, 1);
        check("rd1_data", data_out, 6'h05);
        check("rd1_valid", valid_out, 1);
        cyc(0, 6'h00, 1);
        check("rd2_data", data_out, 6'h0A);
        check("rd2_valid", valid_out, 1);
        cyc(0, 6'h00, 1);
        check("rd3_data", data_out, 6'h15);
        check("rd3_valid", valid_out, 1);
        check("rd3_count", count, 0);
        check("rd3_empty", empty, 1);
        cyc(0, 6'h00, 0);
        check("hold_valid", valid_out, 0);
        check("hold_data", data_out, 6'h15);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) cyc(1, 6'(i), 0);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        check("fill_error", error, 0);
        cyc(1, 6'h06, 0);
        check("ovf_count", count, 4);
        check("ovf_error", error, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 6'h00, 1);
            check("drain_data", data_out, 6'(i));
        end
        check("drain_empty", empty, 1);
        check("drain_error", error, 1);

        // Simultaneous read+write at full, then at empty
        do_reset();
        check("rst2_error", error, 0);
        for (int i = 0; i < 4; i++) cyc(1, 6'h11 + 6'(i), 0);
        cyc(1, 6'h3F, 1);
        check("rw_full_count", count, 4);
        check("rw_full_data", data_out, 6'h11);
        check("rw_full_valid", valid_out, 1);
        check("rw_full_error", error, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 6'h00, 1);
            check("rw_drain_data", data_out, 6'h12 + 6'(i));
        end
        cyc(0, 6'h00, 1);
        check("rw_last_data", data_out, 6'h3F);
        check("rw_last_empty", empty, 1);
        cyc(1, 6'h2A, 1);
        check("rw_empty_count", count, 1);
        check("rw_empty_valid", valid_out, 0);
        check("rw_empty_error", error, 1);
        cyc(0, 6'h00, 1);
        check("rw_empty_data", data_out, 6'h2A);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 6'(i), 0);
            cyc(0, 6'h00, 1);
            check("wrap_data", data_out, 6'(i));
            check("wrap_valid", valid_out, 1);
        end
        check("wrap_count", count, 0);
        check("wrap_error", error, 0);

        // Threshold edge cases
        for (int i = 0; i < 4; i++) cyc(1, 6'(i + 40), 0);
        check("thr_afull3", almost_full, 1);
        af_thr = 2'd0;
        #1;
        check("thr_afull0", almost_full, 0);
        af_thr = 2'd3;
        ae_thr = 2'd0;
        #1;
        check("thr_ae0_full", almost_empty, 0);
        for (int i = 0; i < 3; i++) cyc(0, 6'h00, 1);
        check("thr_ae0_cnt1", almost_empty, 0);
        ae_thr = 2'd1;
        #1;
        check("thr_ae1_cnt1", almost_empty, 1);
        check("thr_af_cnt1", almost_full, 0);
        ae_thr = 2'd0;
        cyc(0, 6'h00, 1);
        check("thr_ae0_cnt0", almost_empty, 1);
        check("thr_ae0_empty", empty, 1);
        ae_thr = 2'd1;

        // Asynchronous reset between edges
        cyc(0, 6'h00, 1);
        check("mid_uflow_err", error, 1);
        cyc(1, 6'h21, 0);
        cyc(1, 6'h22, 0);
        cyc(0, 6'h00, 1);
        check("mid_pre_data", data_out, 6'h21);
        check("mid_pre_count", count, 1);
        #2;
        reset_L = 1'b0;
        #1;
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_valid", valid_out, 0);
        check("mid_data", data_out, 0);
        check("mid_error", error, 0);
        check("mid_aempty", almost_empty, 1);
        check("mid_full", full, 0);
        @(posedge clk);
        #1;
        check("mid_hold_count", count, 0);
        reset_L = 1'b1;
        cyc(0, 6'h00, 1);
        check("post_valid", valid_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
